// File: rtl/spdif_rate_tracker.sv
// spdif_rate_tracker: S/PDIF sample-rate acquisition controller.
// Define SPDIF_RATE_MEAS_EN for pulse-width estimation; default scans.
module spdif_rate_tracker #(
  parameter int NUM_RATE = 5,
  parameter int HALFBIT_W = 5,
  parameter logic [NUM_RATE*HALFBIT_W-1:0] HALFBIT_TABLE =
    {5'd4, 5'd8, 5'd16, 5'd18, 5'd24},
  parameter int TIMEOUT_LOG2 = 14,
  parameter int MEAS_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signal_i,
  input  logic                 locked_i,
  output logic [HALFBIT_W-1:0] clk_per_halfbit_o,
  output logic [NUM_RATE-1:0]  rate_o,
  output logic                 locked_o,
  output logic                 rst_o,
  output logic                 searching_o
);

  localparam int IW = (NUM_RATE > 1) ? $clog2(NUM_RATE) : 1;
  localparam logic [IW-1:0] TOP = IW'(NUM_RATE - 1);

`ifdef SPDIF_RATE_MEAS_EN
  typedef enum logic [1:0] {MEASURE, SELECT, TRY, LOCKED} state_t;
  localparam state_t START = MEASURE;
`else
  typedef enum logic [1:0] {TRY, LOCKED} state_t;
  localparam state_t START = TRY;
`endif

  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx, idx_dn;
  logic [HALFBIT_W-1:0] tbl [NUM_RATE];
  logic [TIMEOUT_LOG2-1:0] tcnt;
  logic tmo;

  for (genvar g = 0; g < NUM_RATE; g++) begin : g_tbl
    assign tbl[g] = HALFBIT_TABLE[g*HALFBIT_W +: HALFBIT_W];
  end

  assign idx_dn = (idx == '0) ? TOP : idx - IW'(1);
  assign tmo = &tcnt;

`ifdef SPDIF_RATE_MEAS_EN
  localparam int RW = HALFBIT_W + 1;
  localparam logic [RW-1:0] RSAT = '1;

  logic sig_q, tog, wend, better;
  logic [RW-1:0] rcnt, min_run, min_nx;
  logic [RW-1:0] ent, dist, bdist;
  logic [1:0] ntr, ntr_nx;
  logic [MEAS_LOG2-1:0] wcnt;
  logic [IW-1:0] si, best, best_nx;

  assign tog = signal_i ^ sig_q;
  assign wend = &wcnt;
  assign ntr_nx = (tog && ntr != 2'd2) ? ntr + 2'd1 : ntr;
  assign min_nx = (tog && ntr != 2'd0 && rcnt < min_run) ?
    rcnt : min_run;

  // line history and saturating cycles since last transition
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
      rcnt <= RSAT;
    end else begin
      sig_q <= signal_i;
      if (tog) rcnt <= RW'(1);
      else if (rcnt != RSAT) rcnt <= rcnt + RW'(1);
    end
  end

  // window timer, transition count and shortest completed run
  always_ff @(posedge clk) begin
    if (rst || state == LOCKED) begin
      wcnt <= '0;
      ntr <= '0;
      min_run <= RSAT;
    end else if (state == MEASURE) begin
      wcnt <= wcnt + MEAS_LOG2'(1);
      ntr <= wend ? 2'd0 : ntr_nx;
      min_run <= (wend && ntr_nx != 2'd2) ? RSAT : min_nx;
    end
  end

  assign ent = {1'b0, tbl[si]};
  assign dist = (min_run >= ent) ? min_run - ent : ent - min_run;
  assign better = (si == '0) || (dist < bdist);
  assign best_nx = better ? si : best;

  // nearest table entry, one candidate per cycle, ties to low index
  always_ff @(posedge clk) begin
    if (rst || state != SELECT) begin
      si <= '0;
      best <= '0;
      bdist <= RSAT;
    end else begin
      si <= si + IW'(1);
      best <= best_nx;
      if (better) bdist <= dist;
    end
  end
`else
  logic unused_sig;
  assign unused_sig = signal_i;
  localparam int unused_meas = MEAS_LOG2;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= START;
    else state <= state_nx;
  end

  // next state and next rate index
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    unique case (state)
`ifdef SPDIF_RATE_MEAS_EN
      MEASURE: if (wend && ntr_nx == 2'd2) state_nx = SELECT;
      SELECT: begin
        if (si == TOP) begin
          state_nx = TRY;
          idx_nx = best_nx;
        end
      end
`endif
      TRY: begin
        if (locked_i) state_nx = LOCKED;
        else if (tmo) idx_nx = idx_dn;
      end
      LOCKED: begin
        if (!locked_i) begin
`ifdef SPDIF_RATE_MEAS_EN
          state_nx = MEASURE;
`else
          state_nx = TRY;
          idx_nx = idx_dn;
`endif
        end
      end
      default: state_nx = START;
    endcase
  end

  // rate index, registered table lookup and lock-entry pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= TOP;
      clk_per_halfbit_o <= tbl[NUM_RATE-1];
      rst_o <= 1'b0;
    end else begin
      idx <= idx_nx;
      clk_per_halfbit_o <= tbl[idx];
      rst_o <= (state == TRY) && locked_i;
    end
  end

  // lock-attempt timer, restarts on TRY entry and after each step
  always_ff @(posedge clk) begin
    if (rst || state != TRY || locked_i || tmo) tcnt <= '0;
    else tcnt <= tcnt + TIMEOUT_LOG2'(1);
  end

  assign rate_o = NUM_RATE'(1) << idx;
  assign locked_o = (state == LOCKED);
  assign searching_o = (state != LOCKED);

endmodule
